operand_extend_pipe: RTL

OPERAND_EXTEND_PIPE -- requirements
Module: operand_extend_pipe

---
 rtl/operand_extend_pipe_if.sv | 25 ++
 rtl/operand_extend_pipe.sv | 115 +++++++++++
 2 files changed

// File: rtl/operand_extend_pipe_if.sv
// Operand/result handshake bundle for operand_extend_pipe.
// slave = the extend block, master = producer/consumer side.
interface operand_extend_pipe_if #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_addr;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] Salida;
  logic             out_err;

  modport slave (
    input  in_valid, in_addr, in_mode, out_ready,
    output in_ready, out_valid, Salida, out_err
  );

  modport master (
    output in_valid, in_addr, in_mode, out_ready,
    input  in_ready, out_valid, Salida, out_err
  );
endinterface

// File: rtl/operand_extend_pipe.sv
// Sign/zero/shift operand extension into a 2-entry registered result FIFO.
// Optional EXT_STATS_EN adds a saturating count of negative signed operands.
module operand_extend_pipe #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_extend_pipe_if.slave  bus
`ifdef EXT_STATS_EN
  ,
  output logic [15:0]           neg_count
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  occ_t             occ_q, occ_d;
  logic             rdy_q;
  logic             vld_q;
  logic [OUT_W-1:0] head_q, tail_q;
  logic             head_err_q, tail_err_q;

  logic             push, pop;
  logic [OUT_W-1:0] sx, zx, res;
  logic             res_err;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = vld_q & bus.out_ready;

  // in_ready depends only on registered state, never on out_ready
  assign bus.in_ready  = rdy_q & (occ_q != FULL);
  assign bus.out_valid = vld_q;
  assign bus.Salida    = head_q;
  assign bus.out_err   = head_err_q;

  always_comb begin
    sx      = {{(OUT_W-IN_W){bus.in_addr[IN_W-1]}}, bus.in_addr};
    zx      = {{(OUT_W-IN_W){1'b0}}, bus.in_addr};
    res     = zx;
    res_err = 1'b0;
    case (bus.in_mode)
      2'd0:    res = sx;
      2'd1:    res = zx;
      2'd2:    res = sx << SHIFT;
      default: begin
        res     = zx;
        res_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= EMPTY;
    else        occ_q <= occ_d;
  end

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      EMPTY:   if (push) occ_d = ONE;
      ONE:     if (push && !pop) occ_d = FULL;
               else if (pop && !push) occ_d = EMPTY;
      FULL:    if (pop) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      vld_q      <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      head_err_q <= 1'b0;
      tail_err_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      vld_q <= (occ_d != EMPTY);
      case (occ_q)
        EMPTY: if (push) begin
          head_q     <= res;
          head_err_q <= res_err;
        end
        ONE: begin
          // push+pop at one entry: new result replaces the departing head
          if (push && pop) begin
            head_q     <= res;
            head_err_q <= res_err;
          end else if (push) begin
            tail_q     <= res;
            tail_err_q <= res_err;
          end
        end
        FULL: if (pop) begin
          head_q     <= tail_q;
          head_err_q <= tail_err_q;
        end
        default: ;
      endcase
    end
  end

`ifdef EXT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      neg_count <= '0;
    else if (push && (bus.in_mode == 2'd0 || bus.in_mode == 2'd2) &&
             bus.in_addr[IN_W-1] && neg_count != 16'hFFFF)
      neg_count <= neg_count + 16'd1;
  end
`endif

endmodule
